// File: rtl/pat_pkg.sv
// Shared constants and state encoding for the sync-pattern serial link.
package pat_pkg;

  localparam int SYNC_W_DEF = 8;
  localparam logic [SYNC_W_DEF-1:0] SYNC_DEF = 8'b00110111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_GAP
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pat_shift_reg.sv
// Loadable left shift register; exposes the current MSB and the bit that becomes MSB after a shift.
module pat_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              msb,
  output logic              next_msb
);

  logic [DATA_W-1:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q << 1;
    end
  end

  assign msb = q[DATA_W-1];

  generate
    if (DATA_W > 1) begin : g_wide
      assign next_msb = q[DATA_W-2];
    end else begin : g_single
      assign next_msb = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pat_frame_tx.sv
// Serial frame transmitter: sync pattern, payload MSB first, then a forced idle gap.
module pat_frame_tx
  import pat_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC     = SYNC_DEF,
  parameter int                GAP_LEN  = 2,
  parameter logic              IDLE_BIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              data,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX = max3(SYNC_W, DATA_W, GAP_LEN);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             data_nxt, done_nxt;
  logic             load, shift;
  logic             sr_msb, sr_next_msb;

  function automatic logic sync_bit(input logic [CNT_W-1:0] c);
    logic b;
    b = 1'b0;
    for (int i = 0; i < SYNC_W; i++) begin
      if (CNT_W'(i) == c) b = SYNC[SYNC_W-1-i];
    end
    return b;
  endfunction

  pat_shift_reg #(
    .DATA_W(DATA_W)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .d       (in_data),
    .msb     (sr_msb),
    .next_msb(sr_next_msb)
  );

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt = ST_SYNC;
          cnt_nxt   = '0;
          load      = 1'b1;
        end
      end
      ST_SYNC: begin
        if (cnt == SYNC_LAST) begin
          state_nxt = ST_PAYLOAD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_PAYLOAD: begin
        shift = 1'b1;
        if (cnt == DATA_LAST) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // data and done are registered, so they are derived from the state being entered
    data_nxt = IDLE_BIT;
    done_nxt = 1'b0;
    case (state_nxt)
      ST_SYNC: data_nxt = sync_bit(cnt_nxt);
      ST_PAYLOAD: begin
        data_nxt = (state == ST_PAYLOAD) ? sr_next_msb : sr_msb;
        done_nxt = (cnt_nxt == DATA_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      data  <= IDLE_BIT;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      data  <= data_nxt;
      done  <= done_nxt;
    end
  end

endmodule
